// File: rtl/jtlabrun_gfxrom_arb_if.sv
// Graphics ROM arbiter bus: tile and object requester slots plus the shared SDRAM read channel.
// master = arbiter side, slave = graphics engine / SDRAM controller side.
interface jtlabrun_gfxrom_arb_if #(
  parameter int AW = 17,
  parameter int DW = 16
) ();
  logic          scr_cs;
  logic [AW-1:0] scr_addr;
  logic [DW-1:0] scr_data;
  logic          scr_ok;
  logic          obj_cs;
  logic [AW-1:0] obj_addr;
  logic [DW-1:0] obj_data;
  logic          obj_ok;
  logic          rom_cs;
  logic [AW:0]   rom_addr;
  logic [DW-1:0] rom_data;
  logic          rom_ok;
  logic          busy;

  modport master (
    input  scr_cs, scr_addr, obj_cs, obj_addr, rom_data, rom_ok,
    output scr_data, scr_ok, obj_data, obj_ok, rom_cs, rom_addr, busy
  );

  modport slave (
    output scr_cs, scr_addr, obj_cs, obj_addr, rom_data, rom_ok,
    input  scr_data, scr_ok, obj_data, obj_ok, rom_cs, rom_addr, busy
  );
endinterface

// File: rtl/jtlabrun_gfxrom_arb.sv
// Round-robin arbiter sharing the graphics SDRAM read port between tile and object fetchers.
// Define JTLABRUN_GFXARB_CACHE_EN for a one-entry hit tag per requester.
//
// state | meaning
// IDLE  | pick a pending requester (or serve a tag hit), register rom_addr/rom_cs
// ISSUE | first cycle of a fetch; rom_ok may be stale from the previous address
// WAIT  | wait for rom_ok, latch data into the granted slot
// DONE  | one idle cycle before the next arbitration
module jtlabrun_gfxrom_arb #(
  parameter int AW = 17,
  parameter int DW = 16
) (
  input logic                  clk,
  input logic                  rst,
  jtlabrun_gfxrom_arb_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic OBJ = 1'b1;

  state_t        state, state_nxt;
  logic          last_gnt, gnt, gnt_nxt;
  logic          rom_cs, busy;
  logic [AW:0]   rom_addr;
  logic [AW-1:0] fetch_addr;
  logic          scr_ok, obj_ok;
  logic [DW-1:0] scr_data, obj_data;
  logic [AW-1:0] scr_tag, obj_tag;
  logic          scr_pend, obj_pend, scr_hit, obj_hit, scr_req, obj_req;
  logic          start, fin, scr_hit_set, obj_hit_set;
`ifdef JTLABRUN_GFXARB_CACHE_EN
  logic          scr_vld, obj_vld;
`endif

  assign gnt        = rom_addr[AW];
  assign fetch_addr = rom_addr[AW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    scr_pend = bus.scr_cs & ~scr_ok;
    obj_pend = bus.obj_cs & ~obj_ok;
`ifdef JTLABRUN_GFXARB_CACHE_EN
    scr_hit  = scr_pend & scr_vld & (bus.scr_addr == scr_tag);
    obj_hit  = obj_pend & obj_vld & (bus.obj_addr == obj_tag);
`else
    scr_hit  = 1'b0;
    obj_hit  = 1'b0;
`endif
    scr_req  = scr_pend & ~scr_hit;
    obj_req  = obj_pend & ~obj_hit;
    gnt_nxt  = (scr_req & obj_req) ? ~last_gnt : obj_req;
    state_nxt = state;
    case (state)
      IDLE:    if (scr_req | obj_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (bus.rom_ok) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start       = 1'b0;
    fin         = 1'b0;
    scr_hit_set = 1'b0;
    obj_hit_set = 1'b0;
    case (state)
      IDLE: begin
        start       = scr_req | obj_req;
        scr_hit_set = scr_hit;
        obj_hit_set = obj_hit;
      end
      WAIT:    fin = bus.rom_ok;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      busy     <= 1'b0;
      last_gnt <= OBJ;
      scr_ok   <= 1'b0;
      obj_ok   <= 1'b0;
      scr_data <= '0;
      obj_data <= '0;
      scr_tag  <= '0;
      obj_tag  <= '0;
`ifdef JTLABRUN_GFXARB_CACHE_EN
      scr_vld  <= 1'b0;
      obj_vld  <= 1'b0;
`endif
    end else begin
      // ok only survives while the requester still asks for the fetched address
      if (scr_ok && (!bus.scr_cs || bus.scr_addr != scr_tag)) scr_ok <= 1'b0;
      if (obj_ok && (!bus.obj_cs || bus.obj_addr != obj_tag)) obj_ok <= 1'b0;
      if (scr_hit_set) scr_ok <= 1'b1;
      if (obj_hit_set) obj_ok <= 1'b1;
      if (start) begin
        rom_cs   <= 1'b1;
        busy     <= 1'b1;
        rom_addr <= {gnt_nxt, gnt_nxt ? bus.obj_addr : bus.scr_addr};
      end
      if (fin) begin
        rom_cs   <= 1'b0;
        busy     <= 1'b0;
        last_gnt <= gnt;
        // data is kept even for an abandoned fetch; ok needs a live, matching request
        if (gnt == OBJ) begin
          obj_data <= bus.rom_data;
          obj_tag  <= fetch_addr;
`ifdef JTLABRUN_GFXARB_CACHE_EN
          obj_vld  <= 1'b1;
`endif
          if (bus.obj_cs && bus.obj_addr == fetch_addr) obj_ok <= 1'b1;
        end else begin
          scr_data <= bus.rom_data;
          scr_tag  <= fetch_addr;
`ifdef JTLABRUN_GFXARB_CACHE_EN
          scr_vld  <= 1'b1;
`endif
          if (bus.scr_cs && bus.scr_addr == fetch_addr) scr_ok <= 1'b1;
        end
      end
    end
  end

  assign bus.rom_cs   = rom_cs;
  assign bus.rom_addr = rom_addr;
  assign bus.busy     = busy;
  assign bus.scr_ok   = scr_ok;
  assign bus.obj_ok   = obj_ok;
  assign bus.scr_data = scr_data;
  assign bus.obj_data = obj_data;

endmodule
